// File: rtl/quant_pkg.sv
// quant_pkg: shared types and constants for the quantizer offset controller.
// Holds the controller FSM state enum, dither LFSR constants and offset limits.
package quant_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic signed [7:0] OFFSET_MAX = 8'sh7F;
    localparam logic signed [7:0] OFFSET_MIN = 8'sh80;

endpackage

// File: rtl/dither_lfsr.sv
// dither_lfsr: free-running 16-bit Fibonacci LFSR used as the dither source.
// Ports: clk, rst (sync, active-high, loads LFSR_SEED), q[15:0] LFSR state.
module dither_lfsr
    import quant_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/quant_ctrl.sv
// quant_ctrl: windowed sign-balance offset tracking loop for a 1-bit quantizer.
// Ports: clk, rst (sync, active-high), enable, y[1:0] (y[1]=1 positive),
//   offset_load/offset_init[7:0] (signed preload), offset[7:0] (signed),
//   random[9:0] (dither word), locked.
// Build option: define QUANT_DITHER_EN to drive random from dither_lfsr;
//   otherwise random is tied to zero.
module quant_ctrl
    import quant_pkg::*;
#(
    parameter int WIN_LOG2     = 10,
    parameter int DEADBAND     = 16,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        y,
    input  logic              offset_load,
    input  logic signed [7:0] offset_init,
    output logic signed [7:0] offset,
    output logic [9:0]        random,
    output logic              locked
);

    localparam int LW = $clog2(LOCK_WINDOWS + 1);
    localparam int BW = WIN_LOG2 + 2;

    localparam logic [WIN_LOG2-1:0] CNT_ONE = WIN_LOG2'(1);
    localparam logic signed [BW-1:0] HALF = BW'(2 ** WIN_LOG2);
    localparam logic signed [BW-1:0] DB_POS = BW'(DEADBAND);
    localparam logic signed [BW-1:0] DB_NEG = BW'(-DEADBAND);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_WINDOWS);
    localparam logic [LW-1:0] LOCK_ONE = LW'(1);

    state_t state;
    state_t state_nxt;

    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   pos_cnt;
    logic [LW-1:0]       lock_cnt;
    logic signed [BW-1:0] bal;
    logic window_last;
    logic enter_accum;
    logic step_up;
    logic step_dn;

    assign window_last = &win_cnt;

    // 2*pos_cnt can reach 2^(WIN_LOG2+1); modular subtraction still
    // lands on the correct signed balance.
    assign bal = $signed({pos_cnt, 1'b0}) - HALF;

    // Saturated steps are not steps: they leave the lock counter running.
    assign step_up = (state == UPDATE) && (bal > DB_POS)
                   && (offset != OFFSET_MAX);
    assign step_dn = (state == UPDATE) && (bal < DB_NEG)
                   && (offset != OFFSET_MIN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable) state_nxt = ACCUM;
            ACCUM: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (window_last) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE:  state_nxt = enable ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
        // A preload restarts any window in progress.
        if (offset_load) begin
            state_nxt = enable ? ACCUM : IDLE;
        end
    end

    assign enter_accum = (state_nxt == ACCUM)
                       && ((state != ACCUM) || offset_load);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
            pos_cnt <= '0;
        end else if (enter_accum) begin
            win_cnt <= '0;
            pos_cnt <= '0;
        end else if (state == ACCUM) begin
            win_cnt <= win_cnt + CNT_ONE;
            pos_cnt <= pos_cnt + {{WIN_LOG2{1'b0}}, y[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            offset   <= '0;
            lock_cnt <= '0;
        end else if (offset_load) begin
            offset   <= offset_init;
            lock_cnt <= '0;
        end else if (step_up) begin
            offset   <= offset + 8'sd1;
            lock_cnt <= '0;
        end else if (step_dn) begin
            offset   <= offset - 8'sd1;
            lock_cnt <= '0;
        end else if (state == UPDATE && lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + LOCK_ONE;
        end
    end

    assign locked = (lock_cnt == LOCK_MAX);

`ifdef QUANT_DITHER_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic unused_bits;

    dither_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign random = lfsr_q[9:0];
    assign unused_bits = ^{y[0], lfsr_q[LFSR_W-1:10]};
`else
    logic unused_bits;

    assign random = '0;
    assign unused_bits = y[0];
`endif

endmodule

// File: tb/tb_quant_ctrl.sv
// tb_quant_ctrl: self-checking bench for quant_ctrl (WIN_LOG2=4, DEADBAND=2).
// Window table plus hand sequences; offset/locked checked via a due-cycle scoreboard.
module tb_quant_ctrl;

    localparam int WL  = 4;
    localparam int DB  = 2;
    localparam int LKW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] y;
    logic       offset_load;
    logic [7:0] offset_init;
    logic [7:0] offset;
    logic [9:0] random;
    logic       locked;

    quant_ctrl #(
        .WIN_LOG2     (WL),
        .DEADBAND     (DB),
        .LOCK_WINDOWS (LKW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .y           (y),
        .offset_load (offset_load),
        .offset_init (offset_init),
        .offset      (offset),
        .random      (random),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int unsigned due;
        logic [7:0]  off;
        logic        lk;
        int          id;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int         p;
        bit         alt;
        logic [7:0] off;
        logic       lk;
    } vec_t;

    vec_t vt[14];

    logic [7:0] exp_off;
    logic       exp_lock;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk($sformatf("win%0d offset", e.id), offset, e.off);
            chk($sformatf("win%0d locked", e.id), locked, e.lk);
        end
    end

    logic [15:0] ref_lfsr;
    bit          rchk = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ref_lfsr <= 16'hACE1;
        end else begin
            ref_lfsr <= {ref_lfsr[14:0],
                         ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
        end
    end

    function automatic logic [9:0] exp_rand();
`ifdef QUANT_DITHER_EN
        return ref_lfsr[9:0];
`else
        return 10'h000;
`endif
    endfunction

    always @(negedge clk) begin
        if (rchk) chk("random", random, exp_rand());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        enable = 1'b1;
        tick();
    endtask

    // Drives one 16-sample window plus its UPDATE cycle. Expectations:
    // old values on the last ACCUM cycle, new ones right after UPDATE.
    task automatic run_window(input int p, input bit alt, input bit ld,
                              input logic [7:0] ini, input logic [7:0] eo,
                              input logic el, input int id);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            y = {(alt ? (i % 2 == 0) : (i < p)), 1'($urandom)};
            tick();
        end
        y = (p >= 8) ? 2'b00 : 2'b10;
        offset_load = ld;
        offset_init = ini;
        e.due = cyc;     e.off = exp_off; e.lk = exp_lock; e.id = id;
        sb.push_back(e);
        e.due = cyc + 1; e.off = eo;      e.lk = el;       e.id = id;
        sb.push_back(e);
        tick();
        offset_load = 1'b0;
        exp_off  = eo;
        exp_lock = el;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        offset_load = 1'b0;
        offset_init = 8'h00;
        y = 2'b00;
        tick();
        tick();
        rchk = 1'b1;
        chk("rst offset", offset, 8'h00);
        chk("rst locked", locked, 1'b0);
        chk("rst random", random, exp_rand());
        rst = 1'b0;
        tick();

        // p = positives per window; hold band is p = 7..9
        vt[0]  = '{16, 1'b0, 8'h01, 1'b0};
        vt[1]  = '{16, 1'b0, 8'h02, 1'b0};
        vt[2]  = '{10, 1'b0, 8'h03, 1'b0};
        vt[3]  = '{9,  1'b0, 8'h03, 1'b0};
        vt[4]  = '{8,  1'b0, 8'h03, 1'b0};
        vt[5]  = '{7,  1'b0, 8'h03, 1'b0};
        vt[6]  = '{8,  1'b0, 8'h03, 1'b1};
        vt[7]  = '{8,  1'b0, 8'h03, 1'b1};
        vt[8]  = '{6,  1'b0, 8'h02, 1'b0};
        vt[9]  = '{0,  1'b0, 8'h01, 1'b0};
        vt[10] = '{8,  1'b1, 8'h01, 1'b0};
        vt[11] = '{8,  1'b1, 8'h01, 1'b0};
        vt[12] = '{8,  1'b1, 8'h01, 1'b0};
        vt[13] = '{8,  1'b1, 8'h01, 1'b1};

        exp_off  = 8'h00;
        exp_lock = 1'b0;
        start();
        for (int i = 0; i < 14; i++) begin
            run_window(vt[i].p, vt[i].alt, 1'b0, 8'h00,
                       vt[i].off, vt[i].lk, i);
        end

        // Preload wins over an incrementing UPDATE and clears lock
        run_window(16, 1'b0, 1'b1, 8'hF0, 8'hF0, 1'b0, 100);
        run_window(16, 1'b0, 1'b0, 8'h00, 8'hF1, 1'b0, 101);

        // Preload in IDLE, then saturation at +127 counts toward lock
        enable = 1'b0;
        tick();
        offset_load = 1'b1;
        offset_init = 8'h7F;
        tick();
        offset_load = 1'b0;
        chk("idle load offset", offset, 8'h7F);
        chk("idle load locked", locked, 1'b0);
        y = 2'b10;
        repeat (20) tick();
        chk("idle hold offset", offset, 8'h7F);
        exp_off  = 8'h7F;
        exp_lock = 1'b0;
        start();
        run_window(16, 1'b0, 1'b0, 8'h00, 8'h7F, 1'b0, 200);
        run_window(16, 1'b0, 1'b0, 8'h00, 8'h7F, 1'b0, 201);
        run_window(16, 1'b0, 1'b0, 8'h00, 8'h7F, 1'b0, 202);
        run_window(16, 1'b0, 1'b0, 8'h00, 8'h7F, 1'b1, 203);
        run_window(0,  1'b0, 1'b0, 8'h00, 8'h7E, 1'b0, 204);

        // Reset mid-window overrides a simultaneous preload
        offset_load = 1'b1;
        offset_init = 8'h05;
        tick();
        offset_load = 1'b0;
        chk("run load offset", offset, 8'h05);
        y = 2'b10;
        repeat (8) tick();
        rst = 1'b1;
        offset_load = 1'b1;
        offset_init = 8'h33;
        tick();
        rst = 1'b0;
        offset_load = 1'b0;
        chk("mid rst offset", offset, 8'h00);
        chk("mid rst locked", locked, 1'b0);
        exp_off  = 8'h00;
        exp_lock = 1'b0;
        start();
        run_window(16, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 300);

        // Enable drop discards the partial window
        y = 2'b10;
        repeat (8) tick();
        enable = 1'b0;
        tick();
        repeat (5) tick();
        chk("drop hold offset", offset, 8'h01);
        chk("drop hold locked", locked, 1'b0);
        start();
        run_window(8, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 400);

        enable = 1'b0;
        repeat (600) begin
            y = 2'($urandom);
            tick();
        end

        tick();
        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
